ls166_deser: RTL and testbench

Serial-to-parallel receiver for bit streams produced by the team's ls166-style parallel-in/serial-out shifter, which loads on an active-low load and shifts MSB first. The block rebuilds each byte with an internal shift register and a 3-bit bit counter, both re-aligned by the transmitter's load strobe, and queues completed bytes in a small show-ahead FIFO. It sits on the consumer side of a video or data serial link, for example a pixel-stream checker or a readback path. It also reports overflow and framing errors as sticky flags.

---
 rtl/ls166_deser.sv | 116 +++++++++++
 tb/tb_ls166_deser.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ls166_deser.sv
// Serial-to-parallel receiver for ls166-style MSB-first streams. The transmitter's load
// strobe re-frames each byte; completed bytes wait in a show-ahead FIFO with sticky error flags.
module ls166_deser #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_clr,
    input  logic                     sin,
    input  logic                     n_load,
    input  logic                     inh,
    input  logic                     rd,
    input  logic                     clr_err,
    output logic [7:0]               dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     ferr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [6:0]    sr_q, sr_d;
    logic [2:0]    bc_q, bc_d;
    logic          armed_q, armed_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          ferr_q, ferr_d;
    logic [7:0]    mem_q [DEPTH];

    logic       sync;
    logic       sample;
    logic       push;
    logic       pop;
    logic       full;
    logic       accept;
    logic       drop;
    logic       frame_err;
    logic [7:0] push_byte;

    // Sync takes priority over inhibit; sin on a sync edge still holds the previous word.
    always_comb begin
        sync      = ~n_load;
        sample    = n_load & ~inh & armed_q;
        push      = sample & (bc_q == 3'd7);
        push_byte = {sr_q, sin};
        pop       = rd & (cnt_q != '0);
        full      = (cnt_q == CW'(DEPTH));
        accept    = push & (~full | pop);
        drop      = push & full & ~pop;
        frame_err = sync & armed_q & (bc_q != 3'd0);
    end

    always_comb begin
        sr_d    = sr_q;
        bc_d    = bc_q;
        armed_d = armed_q | sync;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        if (sync) begin
            bc_d = 3'd0;
        end else if (sample) begin
            sr_d = {sr_q[5:0], sin};
            bc_d = bc_q + 3'd1;
        end
        if (accept) wp_d = wp_q + 1'b1;
        if (pop)    rp_d = rp_q + 1'b1;
        if (accept && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!accept && pop) cnt_d = cnt_q - CW'(1);
        // A new error on the clearing edge must survive the clear.
        ovf_d  = drop      | (ovf_q  & ~clr_err);
        ferr_d = frame_err | (ferr_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            sr_q    <= '0;
            bc_q    <= '0;
            armed_q <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            bc_q    <= bc_d;
            armed_q <= armed_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (accept) begin
            mem_q[wp_q] <= push_byte;
        end
    end

    always_comb begin
        valid = (cnt_q != '0);
        dout  = valid ? mem_q[rp_q] : 8'h00;
        count = cnt_q;
        ovf   = ovf_q;
        ferr  = ferr_q;
    end

endmodule

// File: tb/tb_ls166_deser.sv
// Directed bench for ls166_deser: framing, inhibit, overflow, framing errors and reset,
// with a byte scoreboard checked on every read.
module tb_ls166_deser;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   n_clr;
    logic                   sin;
    logic                   n_load;
    logic                   inh;
    logic                   rd;
    logic                   clr_err;
    logic [7:0]             dout;
    logic                   valid;
    logic [$clog2(DEPTH):0] count;
    logic                   ovf;
    logic                   ferr;

    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    ls166_deser #(.DEPTH(DEPTH)) dut (
        .clk(clk), .n_clr(n_clr), .sin(sin), .n_load(n_load), .inh(inh),
        .rd(rd), .clr_err(clr_err), .dout(dout), .valid(valid), .count(count),
        .ovf(ovf), .ferr(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync_edge();
        n_load = 1'b0;
        tick();
        n_load = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        inh = 1'b0;
        tick();
        inh = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit queued);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        if (queued) exp_q.push_back(b);
    endtask

    task automatic read_check(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, valid, 1);
        n_tests++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, dout, e);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_dout"},  dout,  0);
        check({tag, "_count"}, count, 0);
    endtask

    task automatic do_reset();
        n_clr = 1'b0;
        tick();
        n_clr = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        n_clr = 1'b0; sin = 1'b0; n_load = 1'b1; inh = 1'b1; rd = 1'b0; clr_err = 1'b0;
        tick(); tick();
        check_empty("rst");
        check("rst_ovf",  ovf,  0);
        check("rst_ferr", ferr, 0);
        n_clr = 1'b1;

        // Back-to-back frames
        sync_edge();
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hA5 >> i));
        check("b2b_not_yet", valid, 0);
        send_bit(1'b1);
        exp_q.push_back(8'hA5);
        check("b2b_valid", valid, 1);
        check("b2b_dout", dout, 8'hA5);
        check("b2b_cnt1", count, 1);
        sync_edge();
        send_byte(8'h3C, 1);
        check("b2b_cnt2", count, 2);
        check("b2b_ferr", ferr, 0);
        read_check("b2b_rd0");
        read_check("b2b_rd1");
        check_empty("b2b_end");

        // Continuous stream: one sync frames every 8 bits
        sync_edge();
        send_byte(8'h01, 1);
        check("cont_cnt1", count, 1);
        send_byte(8'h80, 1);
        check("cont_cnt2", count, 2);
        send_byte(8'hFF, 1);
        check("cont_cnt3", count, 3);
        check("cont_ferr", ferr, 0);
        read_check("cont_rd0");
        read_check("cont_rd1");
        read_check("cont_rd2");
        check_empty("cont_end");

        // Inhibit delays the push by exactly the inhibited edges
        sync_edge();
        for (int i = 7; i >= 4; i--) send_bit(1'(8'hC3 >> i));
        inh = 1'b1;
        sin = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 3; i >= 1; i--) send_bit(1'(8'hC3 >> i));
        check("inh_not_yet", valid, 0);
        send_bit(1'b1);
        exp_q.push_back(8'hC3);
        check("inh_cnt", count, 1);
        read_check("inh_rd");
        check_empty("inh_end");

        // Overflow
        sync_edge();
        for (int k = 0; k < 5; k++) send_byte(8'(8'h10 + k), k < DEPTH);
        check("ovf_cnt", count, DEPTH);
        check("ovf_flag", ovf, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clr", ovf, 0);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h20 >> i));
        check("ovf_head", dout, exp_q[0]);
        rd = 1'b1;
        send_bit(1'b0);
        rd = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h20);
        check("ovf_pp_cnt", count, DEPTH);
        check("ovf_pp_flag", ovf, 0);
        read_check("ovf_rd0");
        read_check("ovf_rd1");
        read_check("ovf_rd2");
        read_check("ovf_rd3");
        check_empty("ovf_end");

        // Framing error
        sync_edge();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("ferr_none_yet", ferr, 0);
        sync_edge();
        check("ferr_set", ferr, 1);
        send_byte(8'h5A, 1);
        check("ferr_cnt", count, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ferr_clr", ferr, 0);
        sync_edge();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        clr_err = 1'b1;
        sync_edge();
        clr_err = 1'b0;
        check("ferr_set_wins", ferr, 1);
        check("ferr_cnt2", count, 1);
        read_check("ferr_rd");
        check_empty("ferr_end");
        do_reset();

        // Reset mid-operation
        sync_edge();
        send_byte(8'h66, 1);
        send_byte(8'h99, 1);
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
        check("mid_cnt", count, 2);
        #2;
        n_clr = 1'b0;
        #1;
        check_empty("mid_rst");
        check("mid_ovf", ovf, 0);
        check("mid_ferr", ferr, 0);
        exp_q.delete();
        tick();
        n_clr = 1'b1;
        send_byte(8'hFF, 0);
        send_byte(8'h0F, 0);
        check("mid_unarmed", count, 0);
        sync_edge();
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h77 >> i));
        rd = 1'b1;
        send_bit(1'b1);
        rd = 1'b0;
        exp_q.push_back(8'h77);
        check("empty_pp_cnt", count, 1);
        read_check("mid_rd");
        check_empty("mid_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
